// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg: register offsets and STATUS layout shared by the interrupt controller.
package irq_controller_pkg;
    typedef enum logic [1:0] {
        REG_ENABLE  = 2'd0,
        REG_PENDING = 2'd1,
        REG_TRIGGER = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;
    localparam int STATUS_IFLAG_BIT = 7;
    localparam int STATUS_VECT_LSB = 0;
    function automatic logic [7:0] status_byte(input logic flag, input logic [6:0] vect);
        return (8'(vect) << STATUS_VECT_LSB) | (8'(flag) << STATUS_IFLAG_BIT);
    endfunction
endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if: CPU-side I/O register bus plus interrupt request/acknowledge signals.
interface irq_controller_if #(parameter int VEC_W = 3) ();
    logic             io_re;
    logic             io_we;
    logic [1:0]       io_a;
    logic [7:0]       io_do;
    logic [7:0]       io_di;
    logic             iflag;
    logic [VEC_W-1:0] ivect;
    logic             ack_valid;
    logic [VEC_W-1:0] ack_vect;
    modport master (output io_re, io_we, io_a, io_do, ack_valid, ack_vect,
                    input  io_di, iflag, ivect);
    modport slave  (input  io_re, io_we, io_a, io_do, ack_valid, ack_vect,
                    output io_di, iflag, ivect);
endinterface

// File: rtl/irq_controller_prio_sel.sv
// irq_prio_sel: fixed-priority selector, lowest set request index wins.
module irq_prio_sel #(
    parameter int N_IRQ = 8,
    parameter int VEC_W = 3
) (
    input  logic [N_IRQ-1:0] req,
    output logic             any,
    output logic [VEC_W-1:0] index
);
    always_comb begin
        any = |req;
        index = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (req[i]) index = VEC_W'(i);
    end
endmodule

// File: rtl/irq_controller.sv
// irq_controller: maskable interrupt controller with level channels and registered iflag/ivect.
// Optional edge-triggered channels and TRIGGER register when IRQ_CTRL_EDGE_EN is defined.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int VEC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    irq_controller_if.slave  bus
);
    logic [N_IRQ-1:0] enable_q, enable_d, pending_q, pending_d, trigger_q;
    logic             iflag_q, iflag_d, any;
    logic [VEC_W-1:0] ivect_q, ivect_d, index;
    logic [7:0]       rd_val;
    irq_prio_sel #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) u_prio (
        .req   (pending_q & enable_q),
        .any   (any),
        .index (index)
    );
`ifdef IRQ_CTRL_EDGE_EN
    logic [N_IRQ-1:0] trigger_d, prev_q, prev_d, clr;
    // A new edge wins over a same-cycle W1C or acknowledge.
    always_comb begin
        trigger_d = (bus.io_we && bus.io_a == REG_TRIGGER) ? bus.io_do[N_IRQ-1:0] : trigger_q;
        prev_d = irq_in;
        clr = (bus.io_we && bus.io_a == REG_PENDING) ? bus.io_do[N_IRQ-1:0] : '0;
        for (int i = 0; i < N_IRQ; i++)
            clr[i] = clr[i] | (bus.ack_valid && bus.ack_vect == VEC_W'(i));
        pending_d = (trigger_q & ((pending_q & ~clr) | (irq_in & ~prev_q))) | (~trigger_q & irq_in);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            trigger_q <= '0;
            prev_q <= '0;
        end else begin
            trigger_q <= trigger_d;
            prev_q <= prev_d;
        end
    end
`else
    logic unused_ack;
    assign unused_ack = ^{bus.ack_valid, bus.ack_vect};
    assign trigger_q = '0;
    assign pending_d = irq_in;
`endif
    always_comb begin
        enable_d = (bus.io_we && bus.io_a == REG_ENABLE) ? bus.io_do[N_IRQ-1:0] : enable_q;
        iflag_d = any;
        ivect_d = index;
        rd_val = bus.io_a == REG_ENABLE  ? 8'(enable_q)  :
                 bus.io_a == REG_PENDING ? 8'(pending_q) :
                 bus.io_a == REG_TRIGGER ? 8'(trigger_q) :
                 status_byte(iflag_q, 7'(ivect_q));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= '0;
            pending_q <= '0;
            iflag_q <= 1'b0;
            ivect_q <= '0;
        end else begin
            enable_q <= enable_d;
            pending_q <= pending_d;
            iflag_q <= iflag_d;
            ivect_q <= ivect_d;
        end
    end
    assign bus.io_di = bus.io_re ? rd_val : 8'h00;
    assign bus.iflag = iflag_q;
    assign bus.ivect = ivect_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed and randomized checks of irq_controller against a behavioural model.
module tb_irq_controller;
`ifdef IRQ_CTRL_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;
    int         checks = 0;
    int         errors = 0;
    bit   [7:0] m_en, m_pend, m_trig, m_prev;
    bit         m_iflag;
    int         m_ivect;

    irq_controller_if #(.VEC_W(3)) bus ();
    irq_controller #(.N_IRQ(8), .VEC_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: spec rules applied channel by channel on each rising edge.
    function automatic void model_clock();
        bit         nf = 1'b0;
        int         nv = 0;
        bit   [7:0] np;
        bit         set_i, clr_i;
        for (int i = 7; i >= 0; i--)
            if (m_en[i] && m_pend[i]) begin
                nf = 1'b1;
                nv = i;
            end
        if (rst) begin
            m_en = 0; m_pend = 0; m_trig = 0; m_prev = 0; m_iflag = 0; m_ivect = 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (EDGE && m_trig[i]) begin
                    set_i = irq_in[i] && !m_prev[i];
                    clr_i = (bus.io_we && bus.io_a == 2'd1 && bus.io_do[i]) ||
                            (bus.ack_valid && int'(bus.ack_vect) == i);
                    if (set_i) np[i] = 1'b1;
                    else if (clr_i) np[i] = 1'b0;
                    else np[i] = m_pend[i];
                end else
                    np[i] = irq_in[i];
            end
            m_pend = np;
            m_prev = irq_in;
            m_iflag = nf;
            m_ivect = nv;
            if (bus.io_we && bus.io_a == 2'd0) m_en = bus.io_do;
            if (EDGE && bus.io_we && bus.io_a == 2'd2) m_trig = bus.io_do;
        end
    endfunction

    function automatic logic [7:0] mreg(input logic [1:0] a);
        case (a)
            2'd0: return m_en;
            2'd1: return m_pend;
            2'd2: return EDGE ? m_trig : 8'h00;
            default: return {m_iflag, 4'b0, m_ivect[2:0]};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        chk("iflag", {7'b0, bus.iflag}, {7'b0, m_iflag});
        chk("ivect", {5'b0, bus.ivect}, 8'(m_ivect));
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        bus.io_a = a;
        bus.io_re = 1'b1;
        #1;
        v = bus.io_di;
        bus.io_re = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.io_we = 1'b1;
        bus.io_a = a;
        bus.io_do = d;
        step();
        bus.io_we = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        rst = 1'b1;
        irq_in = 8'h00;
        bus.io_re = 0; bus.io_we = 0; bus.io_a = 0; bus.io_do = 0;
        bus.ack_valid = 0; bus.ack_vect = 0;
        step();
        step();
        rst = 1'b0;
        chk("rst_iflag", {7'b0, bus.iflag}, 8'h00);
        chk("rst_ivect", {5'b0, bus.ivect}, 8'h00);
        // Idle controller with everything enabled
        wr(2'd0, 8'hFF);
        step();
        step();
        chk("idle_iflag", {7'b0, bus.iflag}, 8'h00);
        rd(2'd1, v); chk("idle_pending", v, 8'h00);
        rd(2'd2, v); chk("idle_trigger", v, 8'h00);
        rd(2'd3, v); chk("idle_status", v, 8'h00);
        bus.io_a = 2'd0; #1; chk("no_re_di", bus.io_di, 8'h00);
        // Level channels 3 and 5
        wr(2'd0, 8'h28);
        irq_in = 8'h28;
        step();
        chk("lvl_lat1_iflag", {7'b0, bus.iflag}, 8'h00);
        step();
        chk("lvl_iflag", {7'b0, bus.iflag}, 8'h01);
        chk("lvl_ivect3", {5'b0, bus.ivect}, 8'h03);
        irq_in = 8'h20;
        step();
        step();
        chk("lvl_ivect5", {5'b0, bus.ivect}, 8'h05);
        // Masked pending on channel 1
        irq_in = 8'h02;
        wr(2'd0, 8'h00);
        step();
        step();
        chk("mask_iflag", {7'b0, bus.iflag}, 8'h00);
        rd(2'd1, v); chk("mask_pending", v, 8'h02);
        wr(2'd0, 8'h02);
        step();
        chk("unmask_iflag", {7'b0, bus.iflag}, 8'h01);
        chk("unmask_ivect", {5'b0, bus.ivect}, 8'h01);
        irq_in = 8'h00;
        step();
`ifdef IRQ_CTRL_EDGE_EN
        wr(2'd2, 8'h01);
        wr(2'd0, 8'h01);
        irq_in = 8'h01;
        step();
        irq_in = 8'h00;
        step();
        step();
        rd(2'd1, v); chk("edge_held", v, 8'h01);
        chk("edge_iflag", {7'b0, bus.iflag}, 8'h01);
        bus.ack_valid = 1'b1; bus.ack_vect = 3'd0;
        step();
        bus.ack_valid = 1'b0;
        rd(2'd1, v); chk("ack_pending", v, 8'h00);
        step();
        chk("ack_iflag", {7'b0, bus.iflag}, 8'h00);
        wr(2'd2, 8'h04);
        irq_in = 8'h04;
        step();
        irq_in = 8'h00;
        step();
        irq_in = 8'h04;
        wr(2'd1, 8'h04);
        rd(2'd1, v); chk("set_wins", v & 8'h04, 8'h04);
        irq_in = 8'h00;
        step();
`else
        wr(2'd2, 8'hFF);
        rd(2'd2, v); chk("trig_ignored", v, 8'h00);
        irq_in = 8'h01;
        step();
        irq_in = 8'h00;
        step();
        rd(2'd1, v); chk("pulse_dropped", v, 8'h00);
`endif
        for (int n = 0; n < 400; n++) begin
            rst = $urandom_range(0, 99) == 0;
            irq_in = 8'($urandom);
            bus.io_we = $urandom_range(0, 2) == 0;
            bus.io_a = 2'($urandom);
            bus.io_do = 8'($urandom);
            bus.ack_valid = $urandom_range(0, 2) == 0;
            bus.ack_vect = 3'($urandom);
            step();
            rst = 1'b0;
            bus.io_we = 1'b0;
            bus.ack_valid = 1'b0;
            for (int a = 0; a < 4; a++) begin
                rd(2'(a), v);
                chk("rand_reg", v, mreg(2'(a)));
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter N_IRQ, default 8: number of interrupt channels (legal 2..8).
REQ-002 SHALL have parameter VEC_W, default 3: vector width (legal values satisfy 2^VEC_W >= N_IRQ).
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 irq_in  in  N_IRQ  peripheral interrupt requests, clk domain, no synchronizer.
REQ-006 iflag  out  1  registered interrupt request to core.
REQ-007 ivect  out  VEC_W  registered vector of highest-priority active channel.
REQ-008 ack_valid  in  1  core acknowledges a taken interrupt.
REQ-009 ack_vect  in  VEC_W  vector being acknowledged; qualified by ack_valid.
REQ-010 io_re  in  1  I/O read strobe, pre-qualified by external address decode.
REQ-011 io_we  in  1  I/O write strobe, pre-qualified by external address decode.
REQ-012 io_a  in  2  register select.
REQ-013 io_do  in  8  CPU write data.
REQ-014 io_di  out  8  read data to CPU.

Function
REQ-015 Register map: 0 ENABLE (R/W mask), 1 PENDING (R; W1C), 2 TRIGGER (R/W; 1=edge, 0=level), 3 STATUS (R; bit7=iflag, bits[VEC_W-1:0]=ivect).
REQ-016 Bits at index >= N_IRQ SHALL read 0 and ignore writes; writes to STATUS SHALL be ignored.
REQ-017 io_di SHALL be combinational, equal to the selected register when io_re=1, else 8'h00.
REQ-018 Level channel: pending[i] SHALL be registered irq_in[i] each cycle; W1C and ack have no effect.
REQ-019 Edge channel: pending[i] SHALL set on a cycle where irq_in[i]=1 and prev[i]=0; prev[i] SHALL register irq_in[i] every cycle.
REQ-020 Edge channel: pending[i] SHALL clear on W1C bit i or on ack_valid with ack_vect==i.
REQ-021 Simultaneous set and clear on one edge channel: set SHALL win.
REQ-022 active = pending & ENABLE; iflag SHALL register |active; ivect SHALL register the lowest active index (0 = highest priority), 0 when none active.
REQ-023 Latency: irq_in edge at cycle n -> pending at n+1 -> iflag/ivect valid at n+2.
REQ-024 ack_vect >= N_IRQ or not pending SHALL be ignored without side effects.
REQ-025 Writing TRIGGER SHALL not alter pending; a channel switched edge->level adopts registered irq_in next cycle.
REQ-026 Clearing an ENABLE bit SHALL mask but not clear its pending bit.

Reset
REQ-027 On rst: ENABLE=0, TRIGGER=0, pending=0, prev=0, iflag=0, ivect=0; rst overrides all same-cycle writes and edges.
REQ-028 Since prev resets to 0, an edge channel whose irq_in is high at first post-reset cycle SHALL register an edge.

Configuration
REQ-029 Macro IRQ_CTRL_EDGE_EN: defined -> TRIGGER register and edge logic per REQ-019..021 present.
REQ-030 Not defined -> all channels level-triggered, TRIGGER reads 8'h00, writes ignored, no prev registers, ack has no effect on state.

Structure
REQ-031 Register offsets (ENABLE, PENDING, TRIGGER, STATUS) and STATUS bit positions SHALL live in the shared avr_b3 definitions package/include.
REQ-032 Priority selection SHALL be a parametrised sub-module irq_prio_sel (N_IRQ, VEC_W inputs -> any, index); it replaces the fixed 4-line encoder in top-level wiring.

Verification
REQ-033 Reset, ENABLE=8'hFF, irq_in=8'h00 -> iflag=0, ivect=0, all registers read 8'h00.
REQ-034 ENABLE=8'h28, TRIGGER=0, irq_in=8'h28 -> two cycles later iflag=1, ivect=3; drop irq_in[3] -> ivect=5 next+1.
REQ-035 TRIGGER=8'h01, ENABLE=8'h01, pulse irq_in[0] one cycle -> PENDING=8'h01 held, iflag=1; ack_valid, ack_vect=0 -> PENDING=0, iflag=0 one cycle later.
REQ-036 Edge ch2 pending, W1C 8'h04 in same cycle as new rising edge on ch2 -> PENDING bit2 remains 1.
REQ-037 ENABLE=0 with ch1 pending -> iflag=0, PENDING=8'h02; set ENABLE=8'h02 -> iflag=1, ivect=1.
REQ-038 Build without IRQ_CTRL_EDGE_EN, write TRIGGER=8'hFF -> reads 8'h00, 1-cycle pulse on ch0 not retained after pulse ends.
